// File: rtl/stage3_cnn_mac_acc_pkg.sv
// Derived widths and saturation bounds shared by the stage-3 channel MAC.
package stage3_cnn_mac_acc_pkg;

  function automatic int mul_bw(input int in_bw, input int w_bw);
    return in_bw + w_bw;
  endfunction

  function automatic int sum_bw(input int in_bw, input int w_bw, input int ci);
    return in_bw + w_bw + $clog2(ci);
  endfunction

  function automatic int acc_bw(input int s_bw, input int taps);
    return s_bw + $clog2(taps) + 1;
  endfunction

  // One guard bit so that acc + sum + bias can never wrap before saturation.
  function automatic int fin_bw(input int a_bw, input int b_bw);
    return ((a_bw > b_bw) ? a_bw : b_bw) + 1;
  endfunction

  function automatic longint sat_max(input int out_bw);
    return (longint'(1) << (out_bw - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int out_bw);
    return -(longint'(1) << (out_bw - 1));
  endfunction

endpackage

// File: rtl/stage3_cnn_mac_acc_mul_tree.sv
// Stages 1-2 of the channel MAC: CI signed products, then their registered sum.
module stage3_cnn_mac_acc_mul_tree
  import stage3_cnn_mac_acc_pkg::*;
#(
  parameter int CI     = 3,
  parameter int IN_BW  = 8,
  parameter int W_BW   = 8,
  parameter int SUM_BW = sum_bw(IN_BW, W_BW, CI)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_clear,
  input  logic                  i_en,
  input  logic                  i_valid,
  input  logic [CI*IN_BW-1:0]   i_data,
  input  logic [CI*W_BW-1:0]    i_weight,
  output logic                  o_valid,
  output logic                  o_pending,
  output logic [SUM_BW-1:0]     o_sum
);
  localparam int MUL_BW = mul_bw(IN_BW, W_BW);

  (* use_dsp = "yes" *) logic signed [MUL_BW-1:0] prod_q [CI];
  logic signed [MUL_BW-1:0] prod_d [CI];
  logic signed [SUM_BW-1:0] sum_q, sum_d;
  logic                     valid1_q, valid1_d;
  logic                     valid2_q, valid2_d;

  always_comb begin
    sum_d    = sum_q;
    valid1_d = valid1_q;
    valid2_d = valid2_q;
    for (int c = 0; c < CI; c++) begin
      prod_d[c] = prod_q[c];
      if (i_en)
        prod_d[c] = MUL_BW'($signed(i_data[c*IN_BW +: IN_BW])) *
                    MUL_BW'($signed(i_weight[c*W_BW +: W_BW]));
    end
    if (i_en) begin
      sum_d = '0;
      for (int c = 0; c < CI; c++)
        sum_d = sum_d + SUM_BW'(prod_q[c]);
    end
    // Clear only kills the valids; the data registers are don't-care without them.
    if (i_clear) begin
      valid1_d = 1'b0;
      valid2_d = 1'b0;
    end else if (i_en) begin
      valid1_d = i_valid;
      valid2_d = valid1_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CI; c++) prod_q[c] <= '0;
      sum_q    <= '0;
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
    end else begin
      for (int c = 0; c < CI; c++) prod_q[c] <= prod_d[c];
      sum_q    <= sum_d;
      valid1_q <= valid1_d;
      valid2_q <= valid2_d;
    end
  end

  assign o_valid   = valid2_q;
  assign o_pending = valid1_q | valid2_q;
  assign o_sum     = sum_q;

endmodule

// File: rtl/stage3_cnn_mac_acc.sv
// Stage-3 channel MAC: accumulates TAPS beats of CI-channel dot products, adds bias,
// optional ReLU and saturation, with a single global stall driven by the output handshake.
module stage3_cnn_mac_acc
  import stage3_cnn_mac_acc_pkg::*;
#(
  parameter int   CI      = 3,
  parameter int   IN_BW   = 8,
  parameter int   W_BW    = 8,
  parameter int   TAPS    = 9,
  parameter int   BIAS_BW = 16,
  parameter int   OUT_BW  = 16,
  parameter logic RELU_EN = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_clear,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [CI*IN_BW-1:0] i_data,
  input  logic [CI*W_BW-1:0]  i_weight,
  input  logic [BIAS_BW-1:0]  i_bias,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [OUT_BW-1:0]   o_data,
  output logic                o_sat,
  output logic                o_busy
);
  localparam int SUM_BW = sum_bw(IN_BW, W_BW, CI);
  localparam int ACC_BW = acc_bw(SUM_BW, TAPS);
  localparam int FIN_BW = fin_bw(ACC_BW, BIAS_BW);
  localparam int TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [TAP_W-1:0]         TAP_LAST = TAP_W'(TAPS - 1);
  localparam logic signed [FIN_BW-1:0] OUT_MAX  = FIN_BW'(sat_max(OUT_BW));
  localparam logic signed [FIN_BW-1:0] OUT_MIN  = FIN_BW'(sat_min(OUT_BW));

  logic                      en;
  logic                      s2_valid, pipe_pending;
  logic [SUM_BW-1:0]         s2_sum;
  logic signed [ACC_BW-1:0]  sum_ext;
  logic signed [BIAS_BW-1:0] frame_bias;
  logic signed [FIN_BW-1:0]  final_val, relu_val, sat_val;
  logic                      sat_hit;

  logic [TAP_W-1:0]          tap_q, tap_d;
  logic signed [ACC_BW-1:0]  acc_q, acc_d;
  logic [BIAS_BW-1:0]        bias_p1_q, bias_p1_d, bias_p2_q, bias_p2_d, bias_q, bias_d;
  logic                      o_valid_q, o_valid_d, o_sat_q, o_sat_d;
  logic [OUT_BW-1:0]         o_data_q, o_data_d;

  assign en = !o_valid_q | i_ready;

  stage3_cnn_mac_acc_mul_tree #(
    .CI     (CI),
    .IN_BW  (IN_BW),
    .W_BW   (W_BW),
    .SUM_BW (SUM_BW)
  ) u_mul_tree (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clear   (i_clear),
    .i_en      (en),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .i_weight  (i_weight),
    .o_valid   (s2_valid),
    .o_pending (pipe_pending),
    .o_sum     (s2_sum)
  );

  // Bias rides the pipeline beside its beat so a following frame cannot overwrite it early.
  always_comb begin
    sum_ext    = ACC_BW'($signed(s2_sum));
    frame_bias = (tap_q == '0) ? $signed(bias_p2_q) : $signed(bias_q);
    final_val  = FIN_BW'(sum_ext) + FIN_BW'(frame_bias) +
                 ((tap_q == '0) ? '0 : FIN_BW'(acc_q));
    relu_val   = (RELU_EN && final_val[FIN_BW-1]) ? '0 : final_val;
    sat_val    = relu_val;
    sat_hit    = 1'b0;
    if (relu_val > OUT_MAX) begin
      sat_val = OUT_MAX;
      sat_hit = 1'b1;
    end else if (relu_val < OUT_MIN) begin
      sat_val = OUT_MIN;
      sat_hit = 1'b1;
    end
  end

  always_comb begin
    tap_d     = tap_q;
    acc_d     = acc_q;
    bias_p1_d = bias_p1_q;
    bias_p2_d = bias_p2_q;
    bias_d    = bias_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_sat_d   = o_sat_q;
    if (i_clear) begin
      tap_d     = '0;
      acc_d     = '0;
      o_valid_d = 1'b0;
    end else if (en) begin
      o_valid_d = 1'b0;
      bias_p1_d = i_bias;
      bias_p2_d = bias_p1_q;
      if (s2_valid) begin
        acc_d = (tap_q == '0) ? sum_ext : acc_q + sum_ext;
        if (tap_q == '0) bias_d = bias_p2_q;
        if (tap_q == TAP_LAST) begin
          tap_d     = '0;
          o_valid_d = 1'b1;
          o_data_d  = OUT_BW'(sat_val);
          o_sat_d   = sat_hit;
        end else begin
          tap_d = tap_q + TAP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tap_q     <= '0;
      acc_q     <= '0;
      bias_p1_q <= '0;
      bias_p2_q <= '0;
      bias_q    <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_sat_q   <= 1'b0;
    end else begin
      tap_q     <= tap_d;
      acc_q     <= acc_d;
      bias_p1_q <= bias_p1_d;
      bias_p2_q <= bias_p2_d;
      bias_q    <= bias_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_sat_q   <= o_sat_d;
    end
  end

  assign o_ready = en;
  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_sat   = o_sat_q;
  assign o_busy  = (tap_q != '0) | pipe_pending | o_valid_q;

endmodule

// File: tb/tb_stage3_cnn_mac_acc.sv
// Directed bench for stage3_cnn_mac_acc: one ReLU instance and one non-ReLU instance share stimulus.
module tb_stage3_cnn_mac_acc;
  localparam int CI = 3, IN_BW = 8, W_BW = 8, TAPS = 9, BIAS_BW = 16, OUT_BW = 16;

  logic                clk = 1'b0;
  logic                reset_n, i_clear, i_valid, i_ready;
  logic [CI*IN_BW-1:0] i_data;
  logic [CI*W_BW-1:0]  i_weight;
  logic [BIAS_BW-1:0]  i_bias;
  logic                o_ready, o_valid, o_sat, o_busy;
  logic [OUT_BW-1:0]   o_data;
  logic                nr_ready, nr_valid, nr_sat, nr_busy;
  logic [OUT_BW-1:0]   nr_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage3_cnn_mac_acc #(
    .CI(CI), .IN_BW(IN_BW), .W_BW(W_BW), .TAPS(TAPS),
    .BIAS_BW(BIAS_BW), .OUT_BW(OUT_BW), .RELU_EN(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_clear(i_clear), .i_valid(i_valid),
    .o_ready(o_ready), .i_data(i_data), .i_weight(i_weight), .i_bias(i_bias),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_sat(o_sat),
    .o_busy(o_busy)
  );

  stage3_cnn_mac_acc #(
    .CI(CI), .IN_BW(IN_BW), .W_BW(W_BW), .TAPS(TAPS),
    .BIAS_BW(BIAS_BW), .OUT_BW(OUT_BW), .RELU_EN(1'b0)
  ) dut_nr (
    .clk(clk), .reset_n(reset_n), .i_clear(i_clear), .i_valid(i_valid),
    .o_ready(nr_ready), .i_data(i_data), .i_weight(i_weight), .i_bias(i_bias),
    .o_valid(nr_valid), .i_ready(i_ready), .o_data(nr_data), .o_sat(nr_sat),
    .o_busy(nr_busy)
  );

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One beat with the same feature and weight on every channel; returns #1 after the edge.
  task automatic applyStimulus(input logic [7:0] d, input logic [7:0] w,
                               input logic [15:0] b);
    i_data   = {CI{d}};
    i_weight = {CI{w}};
    i_bias   = b;
    i_valid  = 1'b1;
    @(posedge clk); #1;
    i_valid  = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic [7:0] w, input logic [15:0] b);
    repeat (TAPS) applyStimulus(d, w, b);
  endtask

  // Watches 12 cycles after the final accept: expects one pulse, two cycles after it.
  task automatic collectResult(input string tag, input int exp_data, input int exp_sat,
                               input int exp_nr, input int exp_nr_sat);
    int first = -1, nr_first = -1, pulses = 0, nr_pulses = 0;
    logic signed [31:0] got = 'x, got_sat = 'x, nr_got = 'x, nr_got_sat = 'x;
    for (int k = 0; k < 12; k++) begin
      if (o_valid === 1'b1) begin
        pulses++;
        if (first < 0) begin first = k; got = $signed(o_data); got_sat = o_sat; end
      end
      if (nr_valid === 1'b1) begin
        nr_pulses++;
        if (nr_first < 0) begin nr_first = k; nr_got = $signed(nr_data); nr_got_sat = nr_sat; end
      end
      @(posedge clk); #1;
    end
    checkOutput({tag, ".latency"}, first, 2);
    checkOutput({tag, ".pulses"}, pulses, 1);
    checkOutput({tag, ".data"}, got, exp_data);
    checkOutput({tag, ".sat"}, got_sat, exp_sat);
    checkOutput({tag, ".nr_pulses"}, nr_pulses, 1);
    checkOutput({tag, ".nr_data"}, nr_got, exp_nr);
    checkOutput({tag, ".nr_sat"}, nr_got_sat, exp_nr_sat);
  endtask

  initial begin
    int b_acc, held, bad_hold, a_seen, cyc;
    reset_n = 1'b0; i_clear = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_data = '0; i_weight = '0; i_bias = '0;

    @(posedge clk); #1;
    checkOutput("rst.o_valid", o_valid, 0);
    checkOutput("rst.o_data", $signed(o_data), 0);
    checkOutput("rst.o_sat", o_sat, 0);
    checkOutput("rst.o_busy", o_busy, 0);
    checkOutput("rst.o_ready", o_ready, 1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst.o_valid", o_valid, 0);
    checkOutput("post_rst.o_busy", o_busy, 0);
    checkOutput("post_rst.o_ready", o_ready, 1);

    $display("[TB] ones frame");
    sendFrame(8'd1, 8'd1, 16'd0);
    collectResult("ones", 27, 0, 27, 0);

    $display("[TB] saturation frames");
    sendFrame(8'd127, 8'd127, 16'd0);
    collectResult("pos_sat", 32767, 1, 32767, 1);
    sendFrame(8'd127, 8'h80, 16'd0);
    collectResult("neg_sat", 0, 0, -32768, 1);

    $display("[TB] bias frames");
    sendFrame(8'd1, 8'd1, 16'd5);
    collectResult("bias_pos", 32, 0, 32, 0);
    sendFrame(8'd1, 8'd1, 16'hFFE2);
    collectResult("bias_neg", 0, 0, -3, 0);
    applyStimulus(8'd1, 8'd1, 16'd7);
    repeat (TAPS - 1) applyStimulus(8'd1, 8'd1, 16'd1000);
    collectResult("bias_mid", 34, 0, 34, 0);

    $display("[TB] backpressure");
    sendFrame(8'd1, 8'd1, 16'd0);
    i_ready = 1'b0;
    i_data = {CI{8'd2}}; i_weight = {CI{8'd1}}; i_bias = '0; i_valid = 1'b1;
    b_acc = 0; held = 0; bad_hold = 0; a_seen = 0; cyc = 0;
    while (b_acc < TAPS && cyc < 200) begin
      if (o_valid === 1'b1 && held < 10) begin
        if (a_seen == 0) begin
          a_seen = 1;
          checkOutput("bp.a_data", $signed(o_data), 27);
          checkOutput("bp.a_sat", o_sat, 0);
        end
        if (o_ready !== 1'b0 || o_data !== 16'd27) bad_hold++;
        held++;
        if (held == 10) begin i_ready = 1'b1; #1; end
      end
      if (o_ready === 1'b1) b_acc++;
      @(posedge clk); #1;
      cyc++;
    end
    i_valid = 1'b0;
    checkOutput("bp.a_seen", a_seen, 1);
    checkOutput("bp.hold_errs", bad_hold, 0);
    checkOutput("bp.beats", b_acc, TAPS);
    collectResult("bp.b", 54, 0, 54, 0);

    $display("[TB] clear mid-frame");
    repeat (4) applyStimulus(8'd1, 8'd1, 16'd0);
    i_clear = 1'b1;
    applyStimulus(8'd1, 8'd1, 16'd0);
    i_clear = 1'b0;
    checkOutput("clr.o_busy", o_busy, 0);
    sendFrame(8'd1, 8'd1, 16'd0);
    collectResult("clr", 27, 0, 27, 0);

    $display("[TB] reset mid-frame");
    repeat (4) applyStimulus(8'd1, 8'd1, 16'd0);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst.o_busy", o_busy, 0);
    checkOutput("mid_rst.o_data", $signed(o_data), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    sendFrame(8'd1, 8'd1, 16'd0);
    collectResult("mid_rst", 27, 0, 27, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
